// File: rtl/ebus_diag_master_pkg.sv
// Shared EBUS definitions: master FSM states, EBUS function codes and bus widths.
package ebus_defs;

    localparam int EBUS_CS_W   = 7;
    localparam int EBUS_FUNC_W = 3;
    localparam int EBUS_DATA_W = 36;

    localparam logic [0:EBUS_FUNC_W-1] ebusfREAD    = 3'o0;
    localparam logic [0:EBUS_FUNC_W-1] ebusfWRITE   = 3'o1;
    localparam logic [0:EBUS_FUNC_W-1] ebusfDIAG_RD = 3'o2;
    localparam logic [0:EBUS_FUNC_W-1] ebusfDIAG_WR = 3'o3;

    typedef enum logic [2:0] {
        mstIDLE,
        mstSETUP,
        mstDEMAND,
        mstRELEASE,
        mstDONE
    } tEBUSmstState;

endpackage

// File: rtl/ebus_diag_master_timer.sv
// Loadable up/down counter with a terminal flag; used for the setup hold and the DEMAND timeout.
module ebus_timer #(
    parameter int WIDTH    = 8,
    parameter bit COUNT_UP = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] loadVal_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] termVal_i,
    output logic             term_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (en_i) begin
            count_d = COUNT_UP ? (count_q + ONE) : (count_q - ONE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign term_o = (count_q == termVal_i);

endmodule

// File: rtl/ebus_diag_master.sv
// EBUS diagnostic initiator: sequences CS/FUNC setup, DEMAND/XFER handshake and timeout for one transfer.
module ebus_diag_master
    import ebus_defs::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   EBOX_RESET,
    input  logic                   cmdValid,
    output logic                   cmdReady,
    input  logic                   cmdWrite,
    input  logic [0:EBUS_CS_W-1]   cmdCS,
    input  logic [0:EBUS_FUNC_W-1] cmdFUNC,
    input  logic [0:EBUS_DATA_W-1] cmdData,
    output logic                   rspValid,
    output logic [0:EBUS_DATA_W-1] rspData,
    output logic                   rspTimeout,
    output logic [0:EBUS_CS_W-1]   ebusCS,
    output logic [0:EBUS_FUNC_W-1] ebusFUNC,
    output logic                   ebusDEMAND,
    output logic [0:EBUS_DATA_W-1] ebusDataOut,
    output logic                   ebusDataOE,
    input  logic                   ebusXFER,
    input  logic [0:EBUS_DATA_W-1] ebusDataIn
);

    localparam logic [3:0] SETUP_LOAD   = 4'(SETUP_CYC - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    tEBUSmstState state_q, state_d;

    logic                   wr_q, wr_d;
    logic [0:EBUS_CS_W-1]   cs_q, cs_d;
    logic [0:EBUS_FUNC_W-1] func_q, func_d;
    logic [0:EBUS_DATA_W-1] data_q, data_d;
    logic                   abort_q, abort_d;
    logic [0:EBUS_DATA_W-1] rspData_q, rspData_d;

    logic                   cmdReady_q;
    logic                   rspValid_q;
    logic                   rspTimeout_q;
    logic [0:EBUS_CS_W-1]   ebusCS_q;
    logic [0:EBUS_FUNC_W-1] ebusFUNC_q;
    logic                   ebusDEMAND_q;
    logic [0:EBUS_DATA_W-1] ebusDataOut_q;
    logic                   ebusDataOE_q;

    logic accept;
    logic setupEn;
    logic setupDone;
    logic toLoad;
    logic toEn;
    logic toDone;
    logic capture;
    logic timeoutHit;
    logic busActive;

    ebus_timer #(
        .WIDTH    (4),
        .COUNT_UP (1'b0)
    ) u_setupTimer (
        .clk_i     (clk),
        .rst_i     (EBOX_RESET),
        .load_i    (accept),
        .loadVal_i (SETUP_LOAD),
        .en_i      (setupEn),
        .termVal_i (4'd0),
        .term_o    (setupDone)
    );

    ebus_timer #(
        .WIDTH    (8),
        .COUNT_UP (1'b1)
    ) u_timeoutTimer (
        .clk_i     (clk),
        .rst_i     (EBOX_RESET),
        .load_i    (toLoad),
        .loadVal_i (8'd0),
        .en_i      (toEn),
        .termVal_i (TIMEOUT_LAST),
        .term_o    (toDone)
    );

    // XFER is tested before the terminal count so a late acknowledge always beats the abort.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        setupEn    = 1'b0;
        toLoad     = 1'b0;
        toEn       = 1'b0;
        capture    = 1'b0;
        timeoutHit = 1'b0;
        case (state_q)
            mstIDLE: begin
                if (cmdValid && cmdReady_q) begin
                    accept  = 1'b1;
                    state_d = mstSETUP;
                end
            end
            mstSETUP: begin
                if (setupDone) begin
                    toLoad  = 1'b1;
                    state_d = mstDEMAND;
                end else begin
                    setupEn = 1'b1;
                end
            end
            mstDEMAND: begin
                if (ebusXFER) begin
                    capture = 1'b1;
                    state_d = mstRELEASE;
                end else if (toDone) begin
                    timeoutHit = 1'b1;
                    state_d    = mstRELEASE;
                end else begin
                    toEn = 1'b1;
                end
            end
            mstRELEASE: begin
                if (!ebusXFER) begin
                    state_d = mstDONE;
                end
            end
            mstDONE: begin
                state_d = mstIDLE;
            end
            default: begin
                state_d = mstIDLE;
            end
        endcase
    end

    always_comb begin
        wr_d    = accept ? cmdWrite : wr_q;
        cs_d    = accept ? cmdCS    : cs_q;
        func_d  = accept ? cmdFUNC  : func_q;
        data_d  = accept ? cmdData  : data_q;
        abort_d = abort_q;
        if (accept) begin
            abort_d = 1'b0;
        end else if (timeoutHit) begin
            abort_d = 1'b1;
        end

        // Only reads touch the response data; writes leave the last read value in place.
        rspData_d = rspData_q;
        if (capture && !wr_q) begin
            rspData_d = ebusDataIn;
        end else if (timeoutHit && !wr_q) begin
            rspData_d = '0;
        end

        busActive = (state_d == mstSETUP) || (state_d == mstDEMAND) || (state_d == mstRELEASE);
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (EBOX_RESET) begin
            state_q       <= mstIDLE;
            wr_q          <= 1'b0;
            cs_q          <= '0;
            func_q        <= '0;
            data_q        <= '0;
            abort_q       <= 1'b0;
            rspData_q     <= '0;
            cmdReady_q    <= 1'b1;
            rspValid_q    <= 1'b0;
            rspTimeout_q  <= 1'b0;
            ebusCS_q      <= '0;
            ebusFUNC_q    <= '0;
            ebusDEMAND_q  <= 1'b0;
            ebusDataOut_q <= '0;
            ebusDataOE_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            cs_q          <= cs_d;
            func_q        <= func_d;
            data_q        <= data_d;
            abort_q       <= abort_d;
            rspData_q     <= rspData_d;
            cmdReady_q    <= (state_d == mstIDLE);
            rspValid_q    <= (state_d == mstDONE);
            rspTimeout_q  <= (state_d == mstDONE) && abort_q;
            ebusCS_q      <= busActive ? cs_d : '0;
            ebusFUNC_q    <= busActive ? func_d : '0;
            ebusDEMAND_q  <= (state_d == mstDEMAND);
            ebusDataOut_q <= (busActive && wr_d) ? data_d : '0;
            ebusDataOE_q  <= busActive && wr_d;
        end
    end

    assign cmdReady    = cmdReady_q;
    assign rspValid    = rspValid_q;
    assign rspData     = rspData_q;
    assign rspTimeout  = rspTimeout_q;
    assign ebusCS      = ebusCS_q;
    assign ebusFUNC    = ebusFUNC_q;
    assign ebusDEMAND  = ebusDEMAND_q;
    assign ebusDataOut = ebusDataOut_q;
    assign ebusDataOE  = ebusDataOE_q;

endmodule

// File: tb/tb_ebus_diag_master.sv
// Directed-vector bench for ebus_diag_master with a cycle-level responder model.
module tb_ebus_diag_master;

    localparam logic [0:35] IDLE_BUS = 36'h0F0F0F0F0;

    typedef struct {
        logic        wr;
        logic [0:6]  cs;
        logic [0:2]  fn;
        logic [0:35] wdata;
        int          xDelay;
        int          xHold;
        logic [0:35] rdData;
        logic [0:35] expData;
        logic        expTmo;
        int          expLatency;
        int          expDemand;
    } vec_t;

    typedef struct {
        bit          seen;
        int          latency;
        int          demand;
        int          busBad;
        logic [0:35] sampled;
        logic        tmo;
        logic [0:35] data;
    } res_t;

    logic        clk;
    logic        EBOX_RESET;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdWrite;
    logic [0:6]  cmdCS;
    logic [0:2]  cmdFUNC;
    logic [0:35] cmdData;
    logic        rspValid;
    logic [0:35] rspData;
    logic        rspTimeout;
    logic [0:6]  ebusCS;
    logic [0:2]  ebusFUNC;
    logic        ebusDEMAND;
    logic [0:35] ebusDataOut;
    logic        ebusDataOE;
    logic        ebusXFER;
    logic [0:35] ebusDataIn;

    int total = 0;
    int bad   = 0;

    ebus_diag_master dut (
        .clk         (clk),
        .EBOX_RESET  (EBOX_RESET),
        .cmdValid    (cmdValid),
        .cmdReady    (cmdReady),
        .cmdWrite    (cmdWrite),
        .cmdCS       (cmdCS),
        .cmdFUNC     (cmdFUNC),
        .cmdData     (cmdData),
        .rspValid    (rspValid),
        .rspData     (rspData),
        .rspTimeout  (rspTimeout),
        .ebusCS      (ebusCS),
        .ebusFUNC    (ebusFUNC),
        .ebusDEMAND  (ebusDEMAND),
        .ebusDataOut (ebusDataOut),
        .ebusDataOE  (ebusDataOE),
        .ebusXFER    (ebusXFER),
        .ebusDataIn  (ebusDataIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_cmdReady"},    36'(cmdReady),    36'd1);
        checkOutput({tag, "_rspValid"},    36'(rspValid),    36'd0);
        checkOutput({tag, "_rspTimeout"},  36'(rspTimeout),  36'd0);
        checkOutput({tag, "_rspData"},     rspData,          36'd0);
        checkOutput({tag, "_ebusCS"},      36'(ebusCS),      36'd0);
        checkOutput({tag, "_ebusFUNC"},    36'(ebusFUNC),    36'd0);
        checkOutput({tag, "_ebusDEMAND"},  36'(ebusDEMAND),  36'd0);
        checkOutput({tag, "_ebusDataOut"}, ebusDataOut,      36'd0);
        checkOutput({tag, "_ebusDataOE"},  36'(ebusDataOE),  36'd0);
    endtask

    // One command from the accept cycle to rspValid; while busy a conflicting command is held on the port.
    task automatic applyStimulus(input vec_t v, output res_t r);
        int dStart;
        bit xNow;
        r.seen    = 1'b0;
        r.latency = 0;
        r.demand  = 0;
        r.busBad  = 0;
        r.sampled = '0;
        r.tmo     = 1'b0;
        r.data    = '0;
        dStart    = -1;
        @(negedge clk);
        checkOutput("ready_before_cmd", 36'(cmdReady), 36'd1);
        checkOutput("no_stale_rsp",     36'(rspValid), 36'd0);
        cmdValid = 1'b1;
        cmdWrite = v.wr;
        cmdCS    = v.cs;
        cmdFUNC  = v.fn;
        cmdData  = v.wdata;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (rspValid === 1'b1) begin
                cmdValid  = 1'b0;
                r.seen    = 1'b1;
                r.latency = cyc;
                r.tmo     = rspTimeout;
                r.data    = rspData;
                if (ebusCS !== 7'o0 || ebusFUNC !== 3'o0 || ebusDEMAND !== 1'b0 ||
                    ebusDataOE !== 1'b0 || ebusDataOut !== 36'h0)
                    r.busBad++;
                break;
            end
            cmdValid = 1'b1;
            cmdWrite = ~v.wr;
            cmdCS    = ~v.cs;
            cmdFUNC  = ~v.fn;
            cmdData  = ~v.wdata;
            if (ebusCS !== v.cs || ebusFUNC !== v.fn || ebusDataOE !== v.wr ||
                ebusDataOut !== (v.wr ? v.wdata : 36'h0))
                r.busBad++;
            if (ebusDEMAND === 1'b1) begin
                r.demand++;
                if (dStart < 0) dStart = cyc;
            end
            xNow = (v.xDelay >= 0) && (dStart >= 0) && (cyc >= dStart + v.xDelay) &&
                   (cyc < dStart + v.xDelay + v.xHold);
            if (xNow && !ebusXFER) r.sampled = ebusDataOut;
            ebusXFER   = xNow;
            ebusDataIn = xNow ? v.rdData : IDLE_BUS;
        end
        cmdValid   = 1'b0;
        ebusXFER   = 1'b0;
        ebusDataIn = IDLE_BUS;
    endtask

    task automatic checkResult(input int idx, input vec_t v, input res_t r);
        string p;
        p = $sformatf("v%0d", idx);
        checkOutput({p, "_rsp_seen"}, 36'(r.seen),    36'd1);
        checkOutput({p, "_latency"},  36'(r.latency), 36'(v.expLatency));
        checkOutput({p, "_demand"},   36'(r.demand),  36'(v.expDemand));
        checkOutput({p, "_bus"},      36'(r.busBad),  36'd0);
        checkOutput({p, "_timeout"},  36'(r.tmo),     36'(v.expTmo));
        checkOutput({p, "_rspData"},  r.data,         v.expData);
        if (v.wr) checkOutput({p, "_wr_sampled"}, r.sampled, v.wdata);
    endtask

    vec_t vecs[7];
    vec_t postVec;
    res_t res;
    int   waitCyc;
    int   rspCount;

    initial begin
        // Fields: wr, cs, fn, wdata, xDelay, xHold, rdData, expData, expTmo, expLatency, expDemand
        vecs[0] = '{1'b1, 7'o21, 3'o3, 36'h555555555, 0,  1,  36'h000000000, 36'h000000000, 1'b0, 5,  1};
        vecs[1] = '{1'b0, 7'o14, 3'o2, 36'h000000000, 0,  1,  36'h987654321, 36'h987654321, 1'b0, 5,  1};
        vecs[2] = '{1'b0, 7'o77, 3'o0, 36'h000000000, 5,  2,  36'h123456789, 36'h123456789, 1'b0, 11, 6};
        vecs[3] = '{1'b0, 7'o01, 3'o2, 36'h000000000, 0,  11, 36'hABCDEF012, 36'hABCDEF012, 1'b0, 15, 1};
        vecs[4] = '{1'b0, 7'o14, 3'o3, 36'h000000000, 63, 1,  36'h0FEDCBA98, 36'h0FEDCBA98, 1'b0, 68, 64};
        vecs[5] = '{1'b0, 7'o40, 3'o2, 36'h000000000, -1, 0,  36'h000000000, 36'h000000000, 1'b1, 68, 64};
        vecs[6] = '{1'b0, 7'o14, 3'o2, 36'h000000000, 1,  3,  36'h13579BDF0, 36'h13579BDF0, 1'b0, 8,  2};
        postVec = '{1'b0, 7'o14, 3'o2, 36'h000000000, 0,  1,  36'h246813579, 36'h246813579, 1'b0, 5,  1};

        EBOX_RESET = 1'b1;
        cmdValid   = 1'b0;
        cmdWrite   = 1'b0;
        cmdCS      = '0;
        cmdFUNC    = '0;
        cmdData    = '0;
        ebusXFER   = 1'b0;
        ebusDataIn = IDLE_BUS;
        repeat (2) @(negedge clk);
        EBOX_RESET = 1'b0;
        checkIdle("reset");

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], res);
            checkResult(i, vecs[i], res);
        end

        // Reset pulse while DEMAND is up: transfer dropped, no response, then a clean read.
        @(negedge clk);
        cmdValid = 1'b1;
        cmdWrite = 1'b0;
        cmdCS    = 7'o33;
        cmdFUNC  = 3'o4;
        cmdData  = '0;
        @(negedge clk);
        cmdValid = 1'b0;
        waitCyc  = 0;
        while (ebusDEMAND !== 1'b1 && waitCyc < 20) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("mid_demand_reached", 36'(ebusDEMAND), 36'd1);
        repeat (3) @(negedge clk);
        EBOX_RESET = 1'b1;
        @(negedge clk);
        EBOX_RESET = 1'b0;
        checkIdle("mid_reset");
        rspCount = 0;
        repeat (80) begin
            @(negedge clk);
            if (rspValid === 1'b1) rspCount++;
        end
        checkOutput("no_rsp_after_reset", 36'(rspCount), 36'd0);

        applyStimulus(postVec, res);
        checkResult(7, postVec, res);

        @(negedge clk);
        checkOutput("rsp_one_cycle", 36'(rspValid), 36'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
